// File: rtl/cell_renderer_if.sv
// rtl/cell_renderer_if.sv - command and plot-stream bundle between display controller and cell renderer
interface cell_renderer_if #(
   parameter int GLYPH_IDX_W = 4,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int COLOUR_W    = 3
);
   logic                   start;
   logic [1:0]             mode;
   logic [X_W-1:0]         base_x;
   logic [Y_W-1:0]         base_y;
   logic [GLYPH_IDX_W-1:0] glyph_idx;
   logic [COLOUR_W-1:0]    fg_colour;
   logic [COLOUR_W-1:0]    bg_colour;
   logic [COLOUR_W-1:0]    border_colour;
   logic                   busy;
   logic                   done;
   logic [X_W-1:0]         x;
   logic [Y_W-1:0]         y;
   logic [COLOUR_W-1:0]    colour;
   logic                   plot;
   logic                   plot_ready;

   // Controller / framebuffer-writer side
   modport master (
      output start, mode, base_x, base_y, glyph_idx, fg_colour, bg_colour, border_colour,
      output plot_ready,
      input  busy, done, x, y, colour, plot
   );

   // Renderer side
   modport slave (
      input  start, mode, base_x, base_y, glyph_idx, fg_colour, bg_colour, border_colour,
      input  plot_ready,
      output busy, done, x, y, colour, plot
   );
endinterface

// File: rtl/cell_renderer.sv
// rtl/cell_renderer.sv - streams one minesweeper grid cell (fill, border, glyph) as plot requests
module cell_renderer #(
   parameter int CELL_PX     = 9,
   parameter int GLYPH_W     = 7,
   parameter int GLYPH_H     = 7,
   parameter int NUM_GLYPHS  = 10,
   parameter int GLYPH_IDX_W = 4,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int COLOUR_W    = 3
) (
   input  logic           clock_i,
   input  logic           reset_i,
   cell_renderer_if.slave bus_io
);
   localparam int CNT_W = $clog2(CELL_PX);
   localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(CELL_PX - 1);
   localparam logic [CNT_W-1:0] LAST_GC   = CNT_W'(GLYPH_W - 1);
   localparam logic [CNT_W-1:0] LAST_GR   = CNT_W'(GLYPH_H - 1);

   // Glyph art is drawn as 7x7; each row reads left to right as column 0..6,
   // so flat bit r*7+c (bit 0 = top-left) is row r, character c.
   localparam int ROM_W      = 7;
   localparam int ROM_H      = 7;
   localparam int ROM_GLYPHS = 10;
   localparam logic [ROM_W-1:0] GLYPH_ROM [ROM_GLYPHS*ROM_H] = '{
      7'b0111110, 7'b1100011, 7'b1100111, 7'b1101011, 7'b1110011, 7'b1100011, 7'b0111110,
      7'b0011000, 7'b0111000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0111110,
      7'b0111110, 7'b1100011, 7'b0000011, 7'b0001110, 7'b0111000, 7'b1100000, 7'b1111111,
      7'b0111110, 7'b1100011, 7'b0000011, 7'b0011110, 7'b0000011, 7'b1100011, 7'b0111110,
      7'b0000110, 7'b0001110, 7'b0011110, 7'b0110110, 7'b1111111, 7'b0000110, 7'b0000110,
      7'b1111111, 7'b1100000, 7'b1111110, 7'b0000011, 7'b0000011, 7'b1100011, 7'b0111110,
      7'b0011110, 7'b0110000, 7'b1100000, 7'b1111110, 7'b1100011, 7'b1100011, 7'b0111110,
      7'b1111111, 7'b0000011, 7'b0000110, 7'b0001100, 7'b0011000, 7'b0011000, 7'b0011000,
      7'b0111110, 7'b1100011, 7'b1100011, 7'b0111110, 7'b1100011, 7'b1100011, 7'b0111110,
      7'b0001000, 7'b0101010, 7'b0011100, 7'b1111111, 7'b0011100, 7'b0101010, 7'b0001000
   };

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_BORDER, S_GLYPH, S_DONE} state_t;

   state_t                 state_q;
   logic [1:0]             mode_q;
   logic [X_W-1:0]         base_x_q;
   logic [Y_W-1:0]         base_y_q;
   logic [GLYPH_IDX_W-1:0] glyph_q;
   logic [COLOUR_W-1:0]    fg_q, bg_q, border_q;
   logic [CNT_W-1:0]       row_q, col_q;
   logic                   busy_q, done_q, plot_q;
   logic [X_W-1:0]         x_q;
   logic [Y_W-1:0]         y_q;
   logic [COLOUR_W-1:0]    colour_q;

   logic [CNT_W-1:0]       row_step, col_step;
   logic                   last_px;
   logic                   chain_glyph;
   state_t                 pass_d;
   logic [CNT_W-1:0]       row_d, col_d;
   logic [X_W-1:0]         src_bx;
   logic [Y_W-1:0]         src_by;
   logic [GLYPH_IDX_W-1:0] src_glyph;
   logic [COLOUR_W-1:0]    src_fg, src_bg, src_border;
   logic                   glyph_ok, glyph_bit;
   logic [6:0]             rom_addr;
   logic [2:0]             rom_bit;
   logic [X_W-1:0]         x_d;
   logic [Y_W-1:0]         y_d;
   logic [COLOUR_W-1:0]    colour_d;

   // Successor of the pixel currently on the bus within its own pass, and whether it is the last one
   always_comb begin
      row_step = row_q;
      col_step = col_q;
      last_px  = 1'b0;
      case (state_q)
         S_CLEAR: begin
            last_px = (row_q == LAST_CELL) && (col_q == LAST_CELL);
            if (col_q == LAST_CELL) begin
               col_step = '0;
               row_step = row_q + 1'b1;
            end else begin
               col_step = col_q + 1'b1;
            end
         end
         S_BORDER: begin
            last_px = (row_q == LAST_CELL) && (col_q == LAST_CELL);
            if ((row_q == '0) || (row_q == LAST_CELL)) begin
               if (col_q == LAST_CELL) begin
                  col_step = '0;
                  row_step = row_q + 1'b1;
               end else begin
                  col_step = col_q + 1'b1;
               end
            end else if (col_q == '0) begin
               col_step = LAST_CELL;
            end else begin
               col_step = '0;
               row_step = row_q + 1'b1;
            end
         end
         S_GLYPH: begin
            last_px = (row_q == LAST_GR) && (col_q == LAST_GC);
            if (col_q == LAST_GC) begin
               col_step = '0;
               row_step = row_q + 1'b1;
            end else begin
               col_step = col_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Pick the pixel to present next (first pixel of a new pass or the in-pass successor) and render it
   always_comb begin
      chain_glyph = (state_q == S_BORDER) && last_px && (mode_q == 2'd3);
      src_bx      = base_x_q;
      src_by      = base_y_q;
      src_glyph   = glyph_q;
      src_fg      = fg_q;
      src_bg      = bg_q;
      src_border  = border_q;
      pass_d      = state_q;
      row_d       = row_step;
      col_d       = col_step;
      if (state_q == S_IDLE) begin
         // Pixel 0 is rendered straight from the inputs so it can be on the bus the cycle after start
         src_bx     = bus_io.base_x;
         src_by     = bus_io.base_y;
         src_glyph  = bus_io.glyph_idx;
         src_fg     = bus_io.fg_colour;
         src_bg     = bus_io.bg_colour;
         src_border = bus_io.border_colour;
         row_d      = '0;
         col_d      = '0;
         case (bus_io.mode)
            2'd0:    pass_d = S_CLEAR;
            2'd2:    pass_d = S_GLYPH;
            default: pass_d = S_BORDER;
         endcase
      end else if (chain_glyph) begin
         pass_d = S_GLYPH;
         row_d  = '0;
         col_d  = '0;
      end

      // Out-of-range glyph indices fall back to background rather than reading past the ROM
      glyph_ok  = (int'(src_glyph) < NUM_GLYPHS) && (int'(src_glyph) < ROM_GLYPHS) &&
                  (int'(row_d) < ROM_H) && (int'(col_d) < ROM_W);
      rom_addr  = glyph_ok ? 7'(int'(src_glyph) * ROM_H + int'(row_d)) : 7'd0;
      rom_bit   = glyph_ok ? 3'(ROM_W - 1 - int'(col_d)) : 3'd0;
      glyph_bit = glyph_ok && GLYPH_ROM[rom_addr][rom_bit];

      x_d      = '0;
      y_d      = '0;
      colour_d = '0;
      case (pass_d)
         S_CLEAR: begin
            x_d      = src_bx + X_W'(col_d);
            y_d      = src_by + Y_W'(row_d);
            colour_d = src_bg;
         end
         S_BORDER: begin
            x_d      = src_bx + X_W'(col_d);
            y_d      = src_by + Y_W'(row_d);
            colour_d = src_border;
         end
         S_GLYPH: begin
            x_d      = src_bx + X_W'(1) + X_W'(col_d);
            y_d      = src_by + Y_W'(1) + Y_W'(row_d);
            colour_d = glyph_bit ? src_fg : src_bg;
         end
         default: ;
      endcase
   end

   // Render sequencer: accepts a cell, walks its passes one transfer at a time, then pulses done
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         mode_q   <= '0;
         base_x_q <= '0;
         base_y_q <= '0;
         glyph_q  <= '0;
         fg_q     <= '0;
         bg_q     <= '0;
         border_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               plot_q <= 1'b0;
               if (bus_io.start) begin
                  mode_q   <= bus_io.mode;
                  base_x_q <= bus_io.base_x;
                  base_y_q <= bus_io.base_y;
                  glyph_q  <= bus_io.glyph_idx;
                  fg_q     <= bus_io.fg_colour;
                  bg_q     <= bus_io.bg_colour;
                  border_q <= bus_io.border_colour;
                  state_q  <= pass_d;
                  row_q    <= row_d;
                  col_q    <= col_d;
                  x_q      <= x_d;
                  y_q      <= y_d;
                  colour_q <= colour_d;
                  plot_q   <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            S_CLEAR, S_BORDER, S_GLYPH: begin
               if (plot_q && bus_io.plot_ready) begin
                  if (last_px && !chain_glyph) begin
                     plot_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q  <= pass_d;
                     row_q    <= row_d;
                     col_q    <= col_d;
                     x_q      <= x_d;
                     y_q      <= y_d;
                     colour_q <= colour_d;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_io.busy   = busy_q;
   assign bus_io.done   = done_q;
   assign bus_io.plot   = plot_q;
   assign bus_io.x      = x_q;
   assign bus_io.y      = y_q;
   assign bus_io.colour = colour_q;
endmodule

// File: tb/tb_cell_renderer.sv
// tb/tb_cell_renderer.sv - directed self-checking bench for cell_renderer
module tb_cell_renderer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   t0 = 0;
   bit   rand_ready = 1'b0;

   logic [17:0] act_q[$];
   logic [17:0] exp_q[$];
   int          tcyc_q[$];
   int          done_cyc_q[$];
   logic        stall_prev = 1'b0;
   logic [17:0] stall_val = '0;

   always #5 clk = ~clk;

   cell_renderer_if #(.GLYPH_IDX_W(4), .X_W(8), .Y_W(7), .COLOUR_W(3)) bus();

   cell_renderer dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus_io  (bus.slave)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Sink side: plot_ready either held high or coin-flipped each cycle
   always @(posedge clk) begin
      #1;
      bus.plot_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: records transfers and done pulses, and checks stalled outputs hold
   always @(negedge clk) begin
      if (stall_prev && !rst)
         check_eq("stall_hold", {13'd0, bus.plot, bus.x, bus.y, bus.colour}, {13'd0, 1'b1, stall_val});
      stall_prev <= bus.plot && !bus.plot_ready;
      stall_val  <= {bus.x, bus.y, bus.colour};
      if (bus.plot && bus.plot_ready) begin
         act_q.push_back({bus.x, bus.y, bus.colour});
         tcyc_q.push_back(cyc);
      end
      if (bus.done) done_cyc_q.push_back(cyc);
   end

   function automatic logic [17:0] pk(input int x, input int y, input int c);
      return {8'(x), 7'(y), 3'(c)};
   endfunction

   function automatic logic glyph_bit(input int g, input int r, input int c);
      logic [6:0] rows [7];
      logic [6:0] row;
      case (g)
         1: rows = '{7'b0011000, 7'b0111000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0111110};
         8: rows = '{7'b0111110, 7'b1100011, 7'b1100011, 7'b0111110, 7'b1100011, 7'b1100011, 7'b0111110};
         9: rows = '{7'b0001000, 7'b0101010, 7'b0011100, 7'b1111111, 7'b0011100, 7'b0101010, 7'b0001000};
         default: return 1'b0;
      endcase
      row = rows[3'(r)];
      return row[3'(6 - c)];
   endfunction

   function automatic void build_exp(input int m, input int bx, input int by, input int g,
                                     input int fg, input int bg, input int bc);
      exp_q.delete();
      if (m == 0)
         for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
               exp_q.push_back(pk(bx + c, by + r, bg));
      if (m == 1 || m == 3)
         for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
               if (r == 0 || r == 8 || c == 0 || c == 8)
                  exp_q.push_back(pk(bx + c, by + r, bc));
      if (m == 2 || m == 3)
         for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
               exp_q.push_back(pk(bx + 1 + c, by + 1 + r, glyph_bit(g, r, c) ? fg : bg));
   endfunction

   task automatic start_cell(input int m, input int bx, input int by, input int g,
                             input int fg, input int bg, input int bc);
      @(posedge clk);
      #1;
      act_q.delete();
      tcyc_q.delete();
      done_cyc_q.delete();
      bus.start         = 1'b1;
      bus.mode          = 2'(m);
      bus.base_x        = 8'(bx);
      bus.base_y        = 7'(by);
      bus.glyph_idx     = 4'(g);
      bus.fg_colour     = 3'(fg);
      bus.bg_colour     = 3'(bg);
      bus.border_colour = 3'(bc);
      t0 = cyc;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cyc_q.size() == 0 && n < 400) begin
         @(posedge clk);
         #2;
         n++;
      end
      check_eq({tag, "_done_seen"}, 32'(done_cyc_q.size() != 0), 32'd1);
      check_eq({tag, "_busy_after_done"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic compare_seq(input string tag, input bit contiguous);
      int n;
      int gaps;
      check_eq({tag, "_count"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_eq($sformatf("%s_px%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
      if (contiguous) begin
         gaps = 0;
         for (int i = 0; i < tcyc_q.size(); i++)
            if (tcyc_q[i] != t0 + 1 + i) gaps++;
         check_eq({tag, "_contiguous"}, gaps, 0);
      end
      repeat (3) @(posedge clk);
      #2;
      check_eq({tag, "_single_done"}, done_cyc_q.size(), 1);
      if (done_cyc_q.size() > 0 && tcyc_q.size() > 0)
         check_eq({tag, "_done_timing"}, done_cyc_q[0], tcyc_q[tcyc_q.size() - 1] + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int interior;
      bus.start = 1'b0;
      bus.mode = '0;
      bus.base_x = '0;
      bus.base_y = '0;
      bus.glyph_idx = '0;
      bus.fg_colour = '0;
      bus.bg_colour = '0;
      bus.border_colour = '0;
      bus.plot_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_plot", 32'(bus.plot), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_x", 32'(bus.x), 32'd0);
      check_eq("rst_y", 32'(bus.y), 32'd0);
      check_eq("rst_colour", 32'(bus.colour), 32'd0);
      rst = 1'b0;

      // 1: border at (10,20)
      start_cell(1, 10, 20, 1, 3, 1, 5);
      check_eq("t1_busy_after_start", 32'(bus.busy), 32'd1);
      wait_done("t1");
      build_exp(1, 10, 20, 1, 3, 1, 5);
      if (act_q.size() >= 32) begin
         check_eq("t1_first_px", 32'(act_q[0]), 32'(pk(10, 20, 5)));
         check_eq("t1_last_px", 32'(act_q[31]), 32'(pk(18, 28, 5)));
         check_eq("t1_first_cycle", tcyc_q[0], t0 + 1);
         check_eq("t1_last_cycle", tcyc_q[31], t0 + 32);
      end
      check_eq("t1_done_cycle", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, t0 + 33);
      interior = 0;
      for (int i = 0; i < act_q.size(); i++)
         if (act_q[i][17:10] > 8'd10 && act_q[i][17:10] < 8'd18 &&
             act_q[i][9:3] > 7'd20 && act_q[i][9:3] < 7'd28) interior++;
      check_eq("t1_interior", interior, 0);
      compare_seq("t1", 1'b1);

      // 2: glyph 1, then out-of-range glyph 12
      start_cell(2, 10, 20, 1, 6, 2, 5);
      wait_done("t2a");
      build_exp(2, 10, 20, 1, 6, 2, 5);
      if (act_q.size() >= 49) begin
         check_eq("t2a_px0_bg", 32'(act_q[0]), 32'(pk(11, 21, 2)));
         check_eq("t2a_px2_fg", 32'(act_q[2]), 32'(pk(13, 21, 6)));
         check_eq("t2a_last", 32'(act_q[48]), 32'(pk(17, 27, 2)));
      end
      compare_seq("t2a", 1'b1);
      start_cell(2, 10, 20, 12, 6, 2, 5);
      wait_done("t2b");
      build_exp(2, 10, 20, 12, 6, 2, 5);
      compare_seq("t2b", 1'b1);

      // 3: border then bomb glyph, and clear fill
      start_cell(3, 40, 50, 9, 7, 0, 4);
      wait_done("t3a");
      build_exp(3, 40, 50, 9, 7, 0, 4);
      if (tcyc_q.size() >= 81)
         check_eq("t3a_last_cycle", tcyc_q[80], t0 + 81);
      compare_seq("t3a", 1'b1);
      start_cell(0, 40, 50, 9, 7, 3, 4);
      wait_done("t3b");
      build_exp(0, 40, 50, 9, 7, 3, 4);
      compare_seq("t3b", 1'b1);

      // 4: border then bomb glyph under random back-pressure
      rand_ready = 1'b1;
      start_cell(3, 40, 50, 9, 7, 0, 4);
      wait_done("t4");
      rand_ready = 1'b0;
      build_exp(3, 40, 50, 9, 7, 0, 4);
      compare_seq("t4", 1'b0);

      // 5a: start while busy is ignored, including new field values
      start_cell(1, 30, 40, 8, 1, 2, 6);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      bus.start  = 1'b1;
      bus.mode   = 2'd0;
      bus.base_x = 8'd99;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("t5a");
      build_exp(1, 30, 40, 8, 1, 2, 6);
      compare_seq("t5a", 1'b1);

      // 5b: reset in the middle of a glyph pass aborts without done
      start_cell(2, 30, 40, 8, 1, 2, 6);
      n = 0;
      while (act_q.size() < 20 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      check_eq("t5b_reached_px20", 32'(act_q.size() >= 20), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("t5b_plot_after_rst", 32'(bus.plot), 32'd0);
      check_eq("t5b_busy_after_rst", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check_eq("t5b_no_done", done_cyc_q.size(), 0);
      start_cell(2, 30, 40, 8, 1, 2, 6);
      wait_done("t5c");
      build_exp(2, 30, 40, 8, 1, 2, 6);
      compare_seq("t5c", 1'b1);

      // 6: coordinate wrap at (255,127)
      start_cell(1, 255, 127, 0, 1, 2, 3);
      wait_done("t6");
      build_exp(1, 255, 127, 0, 1, 2, 3);
      if (act_q.size() >= 32) begin
         check_eq("t6_px0", 32'(act_q[0]), 32'(pk(255, 127, 3)));
         check_eq("t6_px1_xwrap", 32'(act_q[1]), 32'(pk(0, 127, 3)));
         check_eq("t6_last", 32'(act_q[31]), 32'(pk(7, 7, 3)));
      end
      compare_seq("t6", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
